// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl
// Time-multiplexed scan controller for the shared 8-digit seven-segment display.
// Each slot lasts REFRESH_DIV cycles and goes to the next enabled digit in
// round-robin order. The first BLANK_CYC cycles of every slot keep all anodes
// off so the previous digit's cathode pattern does not ghost onto the new one.
// The digit value and decimal point are latched at the slot boundary, so
// changes to DIGITS/DP_EN inside a slot wait until that digit's next slot.
//
// Optional feature, enabled with `define SSEG_BRIGHT_EN:
//   Adds the BRIGHT input. The anode is lit only for the first
//   ((BRIGHT+1)*(REFRESH_DIV-BLANK_CYC))/8 cycles after blanking.
//   BRIGHT is sampled at each slot boundary.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   BRIGHT      [2:0] brightness level, 7 = full (SSEG_BRIGHT_EN only)
//   DIGITS      [31:0] hex nibble per digit, digit i = DIGITS[4i+3:4i]
//   DP_EN       [7:0] decimal-point request per digit, 1 = lit
//   DIG_EN      [7:0] digit enable mask, 1 = participates in the scan
//   SSEG_CA     [7:0] cathodes, active-low, {~dp, ~gfedcba}
//   SSEG_AN     [7:0] anodes, active-low, at most one low
//   SCAN_IDX    [2:0] digit owning the current slot
//   FRAME_TICK  1-cycle pulse when the scan wraps around
module sseg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 1000,
  parameter int unsigned NUM_DIGITS  = 8
) (
  input  logic        CLK,
  input  logic        RST,
`ifdef SSEG_BRIGHT_EN
  input  logic [2:0]  BRIGHT,
`endif
  input  logic [31:0] DIGITS,
  input  logic [7:0]  DP_EN,
  input  logic [7:0]  DIG_EN,
  output logic [7:0]  SSEG_CA,
  output logic [7:0]  SSEG_AN,
  output logic [2:0]  SCAN_IDX,
  output logic        FRAME_TICK
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [8:0] MASK9      = (9'd1 << NUM_DIGITS) - 9'd1;
  localparam logic [7:0] VALID_MASK = MASK9[7:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       nib_q, nib_d;
  logic             dp_q, dp_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       ca_q, ca_d;
  logic             tick_q, tick_d;

  logic [7:0] en_mask;
  logic [2:0] next_idx;
  logic       any_en;
  logic       slot_end;
  logic       window_ok;

  // Segment patterns, gfedcba, active-high.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h67;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // (base + k) mod NUM_DIGITS as a digit index.
  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    s = s % NUM_DIGITS;
    return s[2:0];
  endfunction

  assign en_mask  = DIG_EN & VALID_MASK;
  assign slot_end = (cnt_q == CNT_MAX);

  // Search idx+1 .. idx+NUM_DIGITS; the last candidate is idx itself, which
  // covers the single-enabled-digit case.
  always_comb begin
    next_idx = idx_q;
    any_en   = 1'b0;
    for (int unsigned k = 1; k <= NUM_DIGITS; k++) begin
      if (!any_en && en_mask[wrap_idx(idx_q, k)]) begin
        next_idx = wrap_idx(idx_q, k);
        any_en   = 1'b1;
      end
    end
  end

`ifdef SSEG_BRIGHT_EN
  localparam int unsigned LIM_W = $clog2(REFRESH_DIV + 1);
  localparam int unsigned WIN   = REFRESH_DIV - BLANK_CYC;

  logic [LIM_W-1:0] lim_q, lim_d;

  always_comb begin
    lim_d = lim_q;
    if (slot_end) begin
      lim_d = LIM_W'(BLANK_CYC + ((32'(BRIGHT) + 32'd1) * WIN) / 32'd8);
    end
  end

  assign window_ok = (LIM_W'(cnt_q) < lim_q);
`else
  assign window_ok = 1'b1;
`endif

  always_comb begin
    cnt_d  = slot_end ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    nib_d  = nib_q;
    dp_d   = dp_q;
    tick_d = 1'b0;
    if (slot_end) begin
      // With nothing enabled the index holds and no frame is reported.
      if (any_en) begin
        idx_d  = next_idx;
        tick_d = (next_idx <= idx_q);
      end
      nib_d = DIGITS[{next_idx, 2'b00} +: 4];
      dp_d  = DP_EN[next_idx];
    end

    // Enable is checked live so a disabled digit goes dark within a cycle.
    an_d = 8'hFF;
    if ((cnt_q >= BLANK_END) && en_mask[idx_q] && window_ok) begin
      an_d = ~(8'b1 << idx_q);
    end

    ca_d = {~dp_q, ~seg7(nib_q)};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      nib_q  <= '0;
      dp_q   <= 1'b0;
      an_q   <= 8'hFF;
      ca_q   <= 8'hFF;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      nib_q  <= nib_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      ca_q   <= ca_d;
      tick_q <= tick_d;
    end
  end

`ifdef SSEG_BRIGHT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lim_q <= LIM_W'(REFRESH_DIV);
    end else begin
      lim_q <= lim_d;
    end
  end
`endif

  assign SSEG_AN    = an_q;
  assign SSEG_CA    = ca_q;
  assign SCAN_IDX   = idx_q;
  assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with REFRESH_DIV=10, BLANK_CYC=2, NUM_DIGITS=8.
// Time reference: cyc counts rising edges since reset release; all sampling and
// driving happens 1 ns after an edge.
module tb_sseg_scan_ctrl;

  logic        CLK;
  logic        RST;
  logic [2:0]  bright;
  logic [31:0] DIGITS;
  logic [7:0]  DP_EN;
  logic [7:0]  DIG_EN;
  logic [7:0]  SSEG_CA;
  logic [7:0]  SSEG_AN;
  logic [2:0]  SCAN_IDX;
  logic        FRAME_TICK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ticks_seen;
  int an_lit_seen;

  sseg_scan_ctrl #(
    .REFRESH_DIV (10),
    .BLANK_CYC   (2),
    .NUM_DIGITS  (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
`ifdef SSEG_BRIGHT_EN
    .BRIGHT     (bright),
`endif
    .DIGITS     (DIGITS),
    .DP_EN      (DP_EN),
    .DIG_EN     (DIG_EN),
    .SSEG_CA    (SSEG_CA),
    .SSEG_AN    (SSEG_AN),
    .SCAN_IDX   (SCAN_IDX),
    .FRAME_TICK (FRAME_TICK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
  endtask

  task automatic go_to(input int n);
    step(n - cyc);
  endtask

  initial begin
    RST    = 1'b1;
    bright = 3'd7;
    DIGITS = 32'h7654_3210;
    DP_EN  = 8'h00;
    DIG_EN = 8'hFF;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_an", SSEG_AN, 8'hFF);
    check("rst_ca", SSEG_CA, 8'hFF);
    check("rst_idx", SCAN_IDX, 3'd0);
    check("rst_tick", FRAME_TICK, 1'b0);

    // 1. Run into slot 0 with the anode lit, then reset asynchronously mid-slot.
    RST = 1'b0;
    cyc = 0;
    go_to(5);
    check("pre_rst_an", SSEG_AN, 8'hFE);
    check("pre_rst_ca", SSEG_CA, 8'hC0);
    RST = 1'b1;
    #1;
    check("async_rst_an", SSEG_AN, 8'hFF);
    check("async_rst_ca", SSEG_CA, 8'hFF);
    check("async_rst_idx", SCAN_IDX, 3'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc = 0;
    check("rel_idx", SCAN_IDX, 3'd0);

    // 2. Full scan over all eight digits.
    go_to(10);
    check("d1_idx", SCAN_IDX, 3'd1);
    go_to(12);
    check("d1_blank_an", SSEG_AN, 8'hFF);
    go_to(13);
    check("d1_first_an", SSEG_AN, 8'hFD);
    go_to(15);
    check("d1_ca", SSEG_CA, 8'hF9);
    go_to(20);
    check("d1_last_an", SSEG_AN, 8'hFD);
    go_to(21);
    check("d2_blank_an", SSEG_AN, 8'hFF);
    go_to(35);
    check("d3_idx", SCAN_IDX, 3'd3);
    go_to(75);
    check("d7_ca", SSEG_CA, 8'hF8);
    check("d7_an", SSEG_AN, 8'h7F);
    go_to(79);
    check("pre_wrap_tick", FRAME_TICK, 1'b0);
    check("pre_wrap_idx", SCAN_IDX, 3'd7);
    go_to(80);
    check("wrap_tick", FRAME_TICK, 1'b1);
    check("wrap_idx", SCAN_IDX, 3'd0);
    go_to(81);
    check("wrap_tick_end", FRAME_TICK, 1'b0);

    // 3. Sparse enable mask: 0 -> 2 -> 5 -> 0.
    DIG_EN = 8'b0010_0101;
    go_to(95);
    check("sp_idx2", SCAN_IDX, 3'd2);
    go_to(100);
    check("sp_no_tick", FRAME_TICK, 1'b0);
    go_to(105);
    check("sp_idx5", SCAN_IDX, 3'd5);
    check("sp_an5", SSEG_AN, 8'hDF);
    check("sp_ca5", SSEG_CA, 8'h92);
    go_to(110);
    check("sp_wrap_tick", FRAME_TICK, 1'b1);
    check("sp_wrap_idx", SCAN_IDX, 3'd0);
    go_to(125);
    check("sp_idx2b", SCAN_IDX, 3'd2);
    go_to(140);
    check("sp_wrap_tick2", FRAME_TICK, 1'b1);

    // 4. Nothing enabled: dark, frozen, no ticks. Enable is checked live.
    go_to(141);
    DIG_EN = 8'h00;
    go_to(142);
    check("off_live_an", SSEG_AN, 8'hFF);
    ticks_seen  = 0;
    an_lit_seen = 0;
    for (int i = 0; i < 29; i++) begin
      step(1);
      if (FRAME_TICK) ticks_seen++;
      if (SSEG_AN != 8'hFF) an_lit_seen++;
    end
    check("off_ticks", ticks_seen, 0);
    check("off_an_lit", an_lit_seen, 0);
    check("off_idx", SCAN_IDX, 3'd0);
    DIG_EN = 8'h08;
    go_to(180);
    check("one_idx", SCAN_IDX, 3'd3);
    check("one_first_tick", FRAME_TICK, 1'b0);
    go_to(185);
    check("one_an", SSEG_AN, 8'hF7);
    check("one_ca", SSEG_CA, 8'hB0);
    go_to(190);
    check("one_tick1", FRAME_TICK, 1'b1);
    go_to(200);
    check("one_tick2", FRAME_TICK, 1'b1);

    // 5. Mid-slot data change is held off until the next slot of that digit.
    go_to(201);
    DIG_EN = 8'hFF;
    DIGITS = 32'h7654_3A10;
    go_to(272);
    check("d2_idx", SCAN_IDX, 3'd2);
    check("d2_ca_a", SSEG_CA, 8'h88);
    go_to(274);
    DIGITS = 32'h7654_3C10;
    go_to(276);
    check("d2_ca_hold", SSEG_CA, 8'h88);
    go_to(280);
    check("d2_ca_hold_end", SSEG_CA, 8'h88);
    go_to(352);
    check("d2_ca_c", SSEG_CA, 8'hC6);

    // 6. Decimal point plus all segments on digit 0.
    DIGITS = 32'h7654_3C18;
    DP_EN  = 8'h01;
    go_to(410);
    check("dp_wrap_tick", FRAME_TICK, 1'b1);
    go_to(412);
    check("dp_ca", SSEG_CA, 8'h00);
    go_to(415);
    check("dp_an", SSEG_AN, 8'hFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Time-multiplex scheduler for the shared 8-digit seven-segment display on the board. It arbitrates the common cathode bus SSEG_CA among up to 8 digit requesters in round-robin order, skipping digits that are not enabled. Each digit slot starts with a blanking interval, which prevents ghosting. State-machine blocks drive it with 4-bit hex values per digit, which replaces single-digit static drive.

Parameters:
REFRESH_DIV, 100000, CLK cycles per digit slot (>= BLANK_CYC+2)
BLANK_CYC, 1000, cycles at the start of each slot with all anodes off (>= 1)
NUM_DIGITS, 8, number of scanned digits (1..8); unused anodes are held at 1

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
DIGITS  in  32  hex nibble per digit; digit i = DIGITS[4i+3:4i]
DP_EN  in  8  decimal-point request per digit, 1 = lit
DIG_EN  in  8  digit enable mask, 1 = participates in scan
SSEG_CA  out  8  cathodes, active-low; [6:0] = ~gfedcba, [7] = ~DP
SSEG_AN  out  8  anodes, active-low, at most one low
SCAN_IDX  out  3  index of the digit owning the current slot
FRAME_TICK  out  1  1-cycle pulse when the scan wraps

Behaviour:
- Reset (async, immediate): cnt=0, idx=0, latched nibble=0, latched dp=0, SSEG_AN=8'hFF, SSEG_CA=8'hFF, SCAN_IDX=0, FRAME_TICK=0.
- Slot counter cnt runs 0..REFRESH_DIV-1 and wraps every cycle outside reset.
- At cnt==REFRESH_DIV-1 the next edge performs all of the following:
  - cnt<=0.
  - idx<=next, where next = the first index j in idx+1, idx+2, ... (mod NUM_DIGITS) with DIG_EN[j]=1. If only idx is enabled, next=idx.
  - The latch captures DIGITS nibble[next] and DP_EN[next]. Input changes inside a slot are not displayed until the next slot.
  - FRAME_TICK<=1 for that one cycle if next<=idx (wrap, including the single-enabled-digit case). Otherwise FRAME_TICK<=0.
- If DIG_EN[NUM_DIGITS-1:0]==0 at the slot boundary:
  - idx holds.
  - FRAME_TICK stays 0.
  - The anode stays off for the whole slot.
- Outputs are registered with one cycle of latency from cnt/idx:
  - SSEG_AN <= 8'hFF if cnt<BLANK_CYC or DIG_EN[idx]==0 (checked live, so disabling a digit blanks it within 1 cycle).
  - Otherwise SSEG_AN <= ~(8'b1<<idx).
  - SSEG_CA <= {~dp_latched, ~seg(nibble_latched)}, updated every cycle. The value is don't-care while SSEG_AN=FF, but the bench expects the encoded value.
- Segment table seg (gfedcba) is the team's standard hex set:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=67, A=77, B=7C, C=39, D=5E, E=79, F=71
- SCAN_IDX = idx, combinational from the register.
- Overlap rule: the slot boundary has priority. A DIG_EN change in the same cycle as the boundary uses the new DIG_EN value.
- Release from reset: the first slot is digit 0 with nibble 0 latched (not DIGITS). The real data for digit 0 appears from the second frame onward.

Optional Feature:
SSEG_BRIGHT_EN
- Defined:
  - Adds port BRIGHT in 3.
  - Let W = REFRESH_DIV-BLANK_CYC. The anode is active only for BLANK_CYC <= cnt < BLANK_CYC + ((BRIGHT+1)*W)/8, using integer math and a precomputed or registered limit.
  - BRIGHT=7 gives the full window. BRIGHT=0 gives 1/8 of the window.
  - BRIGHT is sampled at the slot boundary.
- Undefined: no BRIGHT port; the anode is active for the whole window after blanking.

Test Plan:
(Sim parameters: REFRESH_DIV=10, BLANK_CYC=2, NUM_DIGITS=8.)
1. Assert RST mid-slot with AN=FE -> SSEG_AN=FF and SSEG_CA=FF in the same cycle. After release: SCAN_IDX=0, first FRAME_TICK 80 cycles later.
2. DIGITS=32'h76543210, DP_EN=0, DIG_EN=FF -> SCAN_IDX steps 0..7 every 10 cycles.
   - Slot for digit 1: SSEG_AN=FD on slot cycles 3..10, SSEG_CA=F9.
   - Slot for digit 7: SSEG_CA=F8.
   - FRAME_TICK one pulse every 80 cycles.
3. DIG_EN=8'b00100101 -> SCAN_IDX sequence 0,2,5,0,2,5. FRAME_TICK every 30 cycles, on the 5->0 transition.
4. DIG_EN=00 -> SSEG_AN=FF constant, FRAME_TICK never pulses, SCAN_IDX frozen.
   - Then set DIG_EN=08 -> from the next boundary idx=3, AN=F7, FRAME_TICK every 10 cycles.
5. DIGITS nibble 2 changes A->C at slot cycle 5 of digit 2 -> SSEG_CA stays 88 for the rest of the slot. It shows C6 in the next digit-2 slot.
6. DP_EN=8'h01, DIGITS nibble0=8 -> during the digit-0 slot SSEG_CA=00. With SSEG_BRIGHT_EN and BRIGHT=3: AN=FE only on slot cycles 3..6.
